// File: rtl/hkspi_pkg.sv
// Shared types and command-field positions for the housekeeping SPI responder.
package hkspi_pkg;

    typedef enum logic [1:0] {
        NOP  = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RDWR = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_e;

    localparam int unsigned CMD_MODE_MSB = 7;
    localparam int unsigned CMD_CNT_MSB  = 5;
    localparam int unsigned CMD_CNT_LSB  = 3;

    function automatic logic mode_reads(mode_e m);
        return (m == RD) || (m == RDWR);
    endfunction

    function automatic logic mode_writes(mode_e m);
        return (m == WR) || (m == RDWR);
    endfunction

endpackage

// File: rtl/hkspi_responder_if.sv
// SPI pad signals and register-file bus of the housekeeping SPI responder.
interface hkspi_responder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              sck;
    logic              csb;
    logic              sdi;
    logic              sdo;
    logic              sdo_oe;
    logic              busy;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              reg_we;
    logic [7:0]        reg_wdata;

    // Responder side: consumes the pads and the read data, drives everything else.
    modport slave (
        input  sck, csb, sdi, reg_rdata,
        output sdo, sdo_oe, busy, reg_addr, reg_re, reg_we, reg_wdata
    );

    // Host and register-bank side.
    modport master (
        output sck, csb, sdi, reg_rdata,
        input  sdo, sdo_oe, busy, reg_addr, reg_re, reg_we, reg_wdata
    );

endinterface

// File: rtl/hkspi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pad input with single-cycle rise/fall pulses.
module hkspi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_resetb,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Reset to 0 so a line already low at reset release produces no falling edge.
    always_ff @(posedge i_clock or negedge i_resetb) begin
        if (!i_resetb) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_prev;
    assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/hkspi_responder.sv
// Oversampled mode-0 SPI responder: command byte, address byte, then an auto-incrementing
// stream of register reads and/or writes.
module hkspi_responder
    import hkspi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 8
) (
    input logic              clock,
    input logic              resetb,
    hkspi_responder_if.slave io_bus
);

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_csb_rise;
    logic w_csb_fall;
    logic w_sdi;
    logic w_bit_last;
    logic [7:0] w_byte;

    logic [SYNC_STAGES-1:0] r_sdi_sync;
    state_e            r_state;
    mode_e             r_mode;
    logic [2:0]        r_cnt;
    logic [2:0]        r_nbytes;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shift_in;
    logic [7:0]        r_shift_out;
    logic [7:0]        r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_re;
    logic              r_we;
    logic              r_step;
    logic              r_ld_pend;
    logic              r_sdo;
    logic              r_sdo_oe;
    logic              r_busy;

    hkspi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sck_sync (
        .i_clock (clock),
        .i_resetb(resetb),
        .i_d     (io_bus.sck),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    hkspi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_csb_sync (
        .i_clock (clock),
        .i_resetb(resetb),
        .i_d     (io_bus.csb),
        .o_rise  (w_csb_rise),
        .o_fall  (w_csb_fall)
    );

    // Same depth as the SCK path so SDI is sampled in step with the detected rising edge.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_sdi_sync <= '0;
        end else begin
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], io_bus.sdi};
        end
    end

    assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
    assign w_byte     = {r_shift_in[6:0], w_sdi};
    assign w_bit_last = (r_bitcnt == 3'd7);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state     <= IDLE;
            r_mode      <= NOP;
            r_cnt       <= 3'd0;
            r_nbytes    <= 3'd0;
            r_bitcnt    <= 3'd0;
            r_shift_in  <= 8'h00;
            r_shift_out <= 8'h00;
            r_wdata     <= 8'h00;
            r_addr      <= '0;
            r_re        <= 1'b0;
            r_we        <= 1'b0;
            r_step      <= 1'b0;
            r_ld_pend   <= 1'b0;
            r_sdo       <= 1'b0;
            r_sdo_oe    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_re   <= 1'b0;
            r_we   <= 1'b0;
            r_step <= 1'b0;

            // The cycle after a completed data byte: the write strobe (if any) has used the
            // old address, so advance it and prefetch the next read byte.
            if (r_step) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_state == DATA && !w_csb_rise && mode_reads(r_mode)) begin
                    r_re      <= 1'b1;
                    r_ld_pend <= 1'b1;
                end
            end

            if (w_csb_rise) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_bitcnt  <= 3'd0;
                r_ld_pend <= 1'b0;
                r_sdo     <= 1'b0;
                r_sdo_oe  <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_csb_fall) begin
                            r_state  <= CMD;
                            r_busy   <= 1'b1;
                            r_bitcnt <= 3'd0;
                        end
                    end
                    CMD: begin
                        if (w_sck_rise) begin
                            r_shift_in <= w_byte;
                            r_bitcnt   <= r_bitcnt + 3'd1;
                            if (w_bit_last) begin
                                r_mode  <= mode_e'(w_byte[CMD_MODE_MSB -: 2]);
                                r_cnt   <= w_byte[CMD_CNT_MSB:CMD_CNT_LSB];
                                r_state <= ADDR;
                            end
                        end
                    end
                    ADDR: begin
                        if (w_sck_rise) begin
                            r_shift_in <= w_byte;
                            r_bitcnt   <= r_bitcnt + 3'd1;
                            if (w_bit_last) begin
                                r_addr   <= ADDR_W'(w_byte);
                                r_nbytes <= 3'd0;
                                if (r_mode == NOP) begin
                                    r_state <= DONE;
                                end else begin
                                    r_state <= DATA;
                                    if (mode_reads(r_mode)) begin
                                        r_re      <= 1'b1;
                                        r_ld_pend <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (w_sck_fall) begin
                            if (r_ld_pend) begin
                                r_sdo       <= io_bus.reg_rdata[7];
                                r_shift_out <= {io_bus.reg_rdata[6:0], 1'b0};
                                r_sdo_oe    <= 1'b1;
                                r_ld_pend   <= 1'b0;
                            end else if (r_sdo_oe) begin
                                r_sdo       <= r_shift_out[7];
                                r_shift_out <= {r_shift_out[6:0], 1'b0};
                            end
                        end
                        if (w_sck_rise) begin
                            r_shift_in <= w_byte;
                            r_bitcnt   <= r_bitcnt + 3'd1;
                            if (w_bit_last) begin
                                if (mode_writes(r_mode)) begin
                                    r_wdata <= w_byte;
                                    r_we    <= 1'b1;
                                end
                                r_step   <= 1'b1;
                                r_nbytes <= r_nbytes + 3'd1;
                                // A zero count means an unlimited stream.
                                if (r_cnt != 3'd0 && (r_nbytes + 3'd1) == r_cnt) begin
                                    r_state   <= DONE;
                                    r_sdo     <= 1'b0;
                                    r_sdo_oe  <= 1'b0;
                                    r_ld_pend <= 1'b0;
                                end
                            end
                        end
                    end
                    DONE: begin
                        r_bitcnt <= 3'd0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign io_bus.sdo       = r_sdo;
    assign io_bus.sdo_oe    = r_sdo_oe;
    assign io_bus.busy      = r_busy;
    assign io_bus.reg_addr  = r_addr;
    assign io_bus.reg_re    = r_re;
    assign io_bus.reg_we    = r_we;
    assign io_bus.reg_wdata = r_wdata;

endmodule

// File: tb/tb_hkspi_responder.sv
// Bench for hkspi_responder: bit-banged SPI host, register-bank model and a
// transaction-level reference model of reads, writes and addressing.
module tb_hkspi_responder;

    localparam int HALF = 100;

    logic clock;
    logic resetb;
    int   total = 0;
    int   bad = 0;
    int   overlap_cnt = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  wr_mem  [256];
    bit          wr_valid[256];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic        oe_q[$];
    logic [7:0]  re_q[$];
    logic [15:0] we_q[$];

    hkspi_responder_if #(.ADDR_W(8)) bus ();

    hkspi_responder #(
        .SYNC_STAGES(2),
        .ADDR_W     (8)
    ) dut (
        .clock (clock),
        .resetb(resetb),
        .io_bus(bus)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Register bank: read data held from the cycle of reg_re; logs every strobe.
    always @(negedge clock) begin
        if (!resetb) begin
            bus.reg_rdata = 8'h00;
        end else begin
            if (bus.reg_re) begin
                re_q.push_back(bus.reg_addr);
                bus.reg_rdata = wr_valid[bus.reg_addr] ? wr_mem[bus.reg_addr] : mem[bus.reg_addr];
            end
            if (bus.reg_we) begin
                we_q.push_back({bus.reg_addr, bus.reg_wdata});
                wr_mem[bus.reg_addr]   = bus.reg_wdata;
                wr_valid[bus.reg_addr] = 1'b1;
            end
            if (bus.reg_re && bus.reg_we) overlap_cnt++;
        end
    end

    function automatic logic [20:0] outs();
        return {bus.sdo, bus.sdo_oe, bus.reg_re, bus.reg_we, bus.busy, bus.reg_addr, bus.reg_wdata};
    endfunction

    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx,
                             output logic oe_first);
        rx = 8'h00;
        oe_first = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.sdi = b[7-i];
            #(HALF);
            bus.sck = 1'b1;
            rx = {rx[6:0], bus.sdo};
            if (i == 0) oe_first = bus.sdo_oe;
            #(HALF);
            bus.sck = 1'b0;
        end
    endtask

    task automatic csb_low();
        bus.csb = 1'b0;
        #(HALF);
    endtask

    task automatic csb_high();
        #(HALF);
        bus.csb = 1'b1;
        #(2 * HALF);
    endtask

    // Full transaction against the reference model: tx_q holds the data bytes to send.
    task automatic run_xact(input logic [7:0] cmd, input logic [7:0] addr, input int extra_bits,
                            input string name);
        logic [1:0] mode;
        logic [7:0] rx, a, exp_b;
        logic       oe, exp_oe, rd, wr;
        int nlim, n, ncomp, nreads, rs, ws, os, nw;
        mode = cmd[7:6];
        nlim = int'(cmd[5:3]);
        n    = tx_q.size();
        rd   = (mode == 2'b01) || (mode == 2'b11);
        wr   = mode[1];
        rx_q.delete();
        oe_q.delete();
        rs = re_q.size();
        ws = we_q.size();
        os = overlap_cnt;

        csb_low();
        send_bits(cmd, 8, rx, oe);
        send_bits(addr, 8, rx, oe);
        foreach (tx_q[i]) begin
            send_bits(tx_q[i], 8, rx, oe);
            rx_q.push_back(rx);
            oe_q.push_back(oe);
        end
        if (extra_bits > 0) send_bits(8'hC3, extra_bits, rx, oe);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_during: got %b want 1", name, bus.busy);
        end
        csb_high();

        ncomp  = (mode == 2'b00) ? 0 : ((nlim != 0 && n > nlim) ? nlim : n);
        nreads = !rd ? 0 : ((nlim != 0 && n >= nlim) ? nlim : n + 1);
        nw     = wr ? ncomp : 0;

        for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            exp_oe = rd && (i < ncomp);
            total++;
            if (oe_q[i] !== exp_oe) begin
                bad++;
                $display("FAIL %s sdo_oe[%0d]: got %b want %b", name, i, oe_q[i], exp_oe);
            end
            if (rd && i < ncomp) begin
                exp_b = ref_mem[a];
                total++;
                if (rx_q[i] !== exp_b) begin
                    bad++;
                    $display("FAIL %s rdata[%0d]: got %h want %h", name, i, rx_q[i], exp_b);
                end
            end
            if (wr && i < ncomp) ref_mem[a] = tx_q[i];
        end

        total++;
        if (re_q.size() - rs !== nreads) begin
            bad++;
            $display("FAIL %s re_count: got %0d want %0d", name, re_q.size() - rs, nreads);
        end
        for (int i = 0; i < nreads && rs + i < re_q.size(); i++) begin
            total++;
            if (re_q[rs+i] !== addr + 8'(i)) begin
                bad++;
                $display("FAIL %s re_addr[%0d]: got %h want %h", name, i, re_q[rs+i],
                         addr + 8'(i));
            end
        end
        total++;
        if (we_q.size() - ws !== nw) begin
            bad++;
            $display("FAIL %s we_count: got %0d want %0d", name, we_q.size() - ws, nw);
        end
        for (int i = 0; i < nw && ws + i < we_q.size(); i++) begin
            total++;
            if (we_q[ws+i] !== {addr + 8'(i), tx_q[i]}) begin
                bad++;
                $display("FAIL %s we[%0d]: got %h want %h", name, i, we_q[ws+i],
                         {addr + 8'(i), tx_q[i]});
            end
        end
        total++;
        if (bus.reg_addr !== addr + 8'(ncomp)) begin
            bad++;
            $display("FAIL %s final_addr: got %h want %h", name, bus.reg_addr, addr + 8'(ncomp));
        end
        total++;
        if ({bus.busy, bus.sdo_oe, bus.sdo} !== 3'b000) begin
            bad++;
            $display("FAIL %s idle_after: got %b want 000", name, {bus.busy, bus.sdo_oe, bus.sdo});
        end
        total++;
        if (overlap_cnt != os) begin
            bad++;
            $display("FAIL %s re_we_overlap: got %0d want 0", name, overlap_cnt - os);
        end
    endtask

    task automatic test_reset();
        #(HALF);
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL reset_in: got %h want 0", outs());
        end
        resetb = 1'b1;
        #(2 * HALF);
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL reset_after: got %h want 0", outs());
        end
    endtask

    task automatic test_single_read();
        tx_q = '{8'h00};
        run_xact(8'h40, 8'h03, 0, "single_read");
    endtask

    task automatic test_write();
        tx_q = '{8'h01};
        run_xact(8'h80, 8'h0b, 0, "write_01");
        tx_q = '{8'h00};
        run_xact(8'h80, 8'h0b, 0, "write_00");
    endtask

    task automatic test_stream_read();
        tx_q.delete();
        for (int i = 0; i < 19; i++) tx_q.push_back(8'($urandom));
        run_xact(8'h40, 8'h00, 0, "stream_read");
    endtask

    task automatic test_counted_read();
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_xact(8'h50, 8'h10, 0, "counted_read");
    endtask

    task automatic test_abort_wrap();
        tx_q = '{8'hAA};
        run_xact(8'h80, 8'hFF, 4, "abort_wrap");
        tx_q = '{8'h5C};
        run_xact(8'h48, 8'hFF, 0, "after_abort");
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        logic       oe;
        int         rs, ws;
        csb_low();
        send_bits(8'h40, 8, rx, oe);
        send_bits(8'h05, 8, rx, oe);
        send_bits(8'h00, 2, rx, oe);
        bus.sdi = 1'b1;
        #(HALF);
        bus.sck = 1'b1;
        #50;
        resetb = 1'b0;
        #20;
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL mid_reset_outs: got %h want 0", outs());
        end
        #30;
        bus.sck = 1'b0;
        #(2 * HALF);
        resetb = 1'b1;
        #(HALF);
        rs = re_q.size();
        ws = we_q.size();
        send_bits(8'h40, 8, rx, oe);
        send_bits(8'h06, 8, rx, oe);
        send_bits(8'hFF, 8, rx, oe);
        total++;
        if ((re_q.size() - rs) + (we_q.size() - ws) !== 0) begin
            bad++;
            $display("FAIL csb_low_at_release_strobes: got %0d want 0",
                     (re_q.size() - rs) + (we_q.size() - ws));
        end
        total++;
        if ({bus.busy, bus.sdo_oe} !== 2'b00) begin
            bad++;
            $display("FAIL csb_low_at_release_busy: got %b want 00", {bus.busy, bus.sdo_oe});
        end
        csb_high();
        tx_q = '{8'h00};
        run_xact(8'h48, 8'h05, 0, "post_reset_read");
    endtask

    task automatic test_random();
        logic [7:0] cmd, addr;
        int         n;
        for (int t = 0; t < 12; t++) begin
            cmd  = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom)};
            addr = 8'($urandom);
            n    = $urandom_range(0, 9);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            run_xact(cmd, addr, $urandom_range(0, 7), $sformatf("random%0d", t));
        end
    endtask

    initial begin
        logic [7:0] stream_v [19];
        stream_v = '{8'h00, 8'h04, 8'h56, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01,
                     8'h00, 8'h00, 8'h00, 8'hff, 8'hef, 8'hff, 8'h03, 8'h12, 8'h04};
        resetb  = 1'b0;
        bus.sck = 1'b0;
        bus.csb = 1'b1;
        bus.sdi = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 19; i++) mem[i] = stream_v[i];
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        #3;
        test_reset();
        test_single_read();
        test_write();
        test_stream_read();
        test_counted_read();
        test_abort_wrap();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
